// File: rtl/chroma_pair_filter_if.sv
// Video bus for chroma_pair_filter: 4:4:4 pixel/timing input side and the
// delayed Y/chroma-source output side (master = source/bench, slave = filter).
interface chroma_pair_filter_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3
);
  localparam int OW = DATA_W + 2;

  logic                       mode;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic                       in_hsync;
  logic                       in_vsync;
  logic                       in_de;
  logic [CHANNELS*OW-1:0]     y_data;
  logic [CHANNELS*OW-1:0]     c_data;
  logic                       pair_start;
  logic                       hsync_out;
  logic                       vsync_out;
  logic                       de_out;

  modport master (
    output mode, in_data, in_hsync, in_vsync, in_de,
    input  y_data, c_data, pair_start, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  mode, in_data, in_hsync, in_vsync, in_de,
    output y_data, c_data, pair_start, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/chroma_pair_filter.sv
// 4:4:4 -> 4:2:2 chroma-source generator (2-tap pair sum / 3-tap [1 2 1]); fixed 3-clk latency,
// no backpressure. Optional line statistics ports enabled by LINE_STATS_EN.
module chroma_pair_filter #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int LEN_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chroma_pair_filter_if.slave  bus
`ifdef LINE_STATS_EN
  ,
  output logic [LEN_W-1:0]     line_len,
  output logic                 line_odd,
  output logic                 line_stb
`endif
);

  localparam int IW = CHANNELS * DATA_W;
  localparam int OW = DATA_W + 2;
  localparam int BW = CHANNELS * OW;

  typedef struct packed {
    logic [IW-1:0] dat;
    logic          hs;
    logic          vs;
    logic          de;
  } stage_t;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} phase_t;

  stage_t        s1, s2, s3;
  phase_t        state_q, state_d;
  logic          mode_q;
  logic          enter_first;
  logic [IW-1:0] prev_dat, next_dat;
  logic [BW-1:0] y_d, pair_sum, tap_sum, c_d;
  logic [BW-1:0] y_q, c_q;
  logic          ps_q, hs_q, vs_q, de_q;

  // Missing neighbours at line edges are replaced by the current pixel.
  assign prev_dat = s3.de ? s3.dat : s2.dat;
  assign next_dat = s1.de ? s1.dat : s2.dat;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [OW-1:0] cur, pv, nx;
    assign cur = {2'b00, s2.dat[g*DATA_W +: DATA_W]};
    assign pv  = {2'b00, prev_dat[g*DATA_W +: DATA_W]};
    assign nx  = {2'b00, next_dat[g*DATA_W +: DATA_W]};
    assign y_d[g*OW +: OW]      = {s2.dat[g*DATA_W +: DATA_W], 2'b00};
    assign pair_sum[g*OW +: OW] = (cur + nx) << 1;
    assign tap_sum[g*OW +: OW]  = pv + (cur << 1) + nx;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s2.de) state_d = FIRST;
      FIRST:   state_d = s2.de ? SECOND : IDLE;
      SECOND:  state_d = s2.de ? FIRST  : IDLE;
      default: state_d = IDLE;
    endcase
    enter_first = s2.de && (state_d == FIRST);
  end

  always_comb begin
    c_d = c_q;
    if (mode_q) begin
      if (s2.de) c_d = tap_sum;
    end else if (enter_first) begin
      c_d = pair_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      state_q <= IDLE;
      mode_q  <= 1'b0;
      y_q     <= '0;
      c_q     <= '0;
      ps_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      s1      <= {bus.in_data, bus.in_hsync, bus.in_vsync, bus.in_de};
      s2      <= s1;
      s3      <= s2;
      state_q <= state_d;
      // Mode is latched only between lines so a line never mixes filters.
      if (!s2.de) mode_q <= bus.mode;
      y_q     <= y_d;
      c_q     <= c_d;
      ps_q    <= enter_first;
      hs_q    <= s2.hs;
      vs_q    <= s2.vs;
      de_q    <= s2.de;
    end
  end

  assign bus.y_data     = y_q;
  assign bus.c_data     = c_q;
  assign bus.pair_start = ps_q;
  assign bus.hsync_out  = hs_q;
  assign bus.vsync_out  = vs_q;
  assign bus.de_out     = de_q;

`ifdef LINE_STATS_EN
  logic [LEN_W-1:0] len_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt  <= '0;
      line_len <= '0;
      line_odd <= 1'b0;
      line_stb <= 1'b0;
    end else if (s3.de && !s2.de) begin
      line_len <= len_cnt;
      line_odd <= len_cnt[0];
      line_stb <= 1'b1;
      len_cnt  <= '0;
    end else begin
      line_stb <= 1'b0;
      if (s2.de && (len_cnt != {LEN_W{1'b1}})) len_cnt <= len_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_chroma_pair_filter.sv
// Directed-vector bench for chroma_pair_filter; channel 0 values are checked against hand-computed results.
module tb_chroma_pair_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   yq[$], cq[$], pq[$];
  int   px[$], ec[$], eps[$];

  chroma_pair_filter_if #(.DATA_W(8), .CHANNELS(3)) bus ();

`ifdef LINE_STATS_EN
  logic [11:0] line_len;
  logic        line_odd;
  logic        line_stb;
  int          stb_cnt = 0;
  int          stb_after_last = 0;
  logic        de_prev = 1'b0;
`endif

  chroma_pair_filter #(.DATA_W(8), .CHANNELS(3), .LEN_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LINE_STATS_EN
    ,
    .line_len (line_len),
    .line_odd (line_odd),
    .line_stb (line_stb)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.de_out) begin
      yq.push_back(int'(bus.y_data[9:0]));
      cq.push_back(int'(bus.c_data[9:0]));
      pq.push_back(int'(bus.pair_start));
    end
`ifdef LINE_STATS_EN
    if (line_stb) begin
      stb_cnt++;
      if (de_prev && !bus.de_out) stb_after_last++;
    end
    de_prev = bus.de_out;
`endif
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input int v);
    logic [7:0] b;
    b = v[7:0];
    bus.in_de   = de;
    bus.in_data = {b, b, b};
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // toggle_at: index of the pixel at which mode is flipped (-1: never)
  task automatic send_line(input int p[$], input int toggle_at);
    for (int i = 0; i < p.size(); i++) begin
      if (i == toggle_at) bus.mode = ~bus.mode;
      drive(1'b1, p[i]);
      cyc();
    end
  endtask

  task automatic check_line(input string tag, input int p[$], input int c[$], input int ps[$]);
    chk({tag, "_len"}, yq.size(), p.size());
    for (int i = 0; i < p.size(); i++) begin
      if (i < yq.size()) begin
        chk($sformatf("%s_y%0d", tag, i), yq[i], 4 * p[i]);
        chk($sformatf("%s_c%0d", tag, i), cq[i], c[i]);
        chk($sformatf("%s_ps%0d", tag, i), pq[i], ps[i]);
      end
    end
    yq.delete(); cq.delete(); pq.delete();
  endtask

  initial begin
    bus.mode     = 1'b0;
    bus.in_data  = '0;
    bus.in_hsync = 1'b0;
    bus.in_vsync = 1'b0;
    bus.in_de    = 1'b0;
    #1;
    chk("rst_y", int'(bus.y_data), 0);
    chk("rst_c", int'(bus.c_data), 0);
    chk("rst_ps", int'(bus.pair_start), 0);
    chk("rst_de", int'(bus.de_out), 0);
    chk("rst_hs", int'(bus.hsync_out), 0);
    chk("rst_vs", int'(bus.vsync_out), 0);
    #20 rst_n = 1'b1;
    idle(3);

    // 1: mode 0 even line, with explicit 3-clk latency and sync pass-through
    bus.in_hsync = 1'b1;
    bus.in_vsync = 1'b1;
    drive(1'b1, 10); cyc();
    bus.in_hsync = 1'b0;
    bus.in_vsync = 1'b0;
    chk("lat1_de", int'(bus.de_out), 0);
    drive(1'b1, 20); cyc();
    chk("lat2_de", int'(bus.de_out), 0);
    drive(1'b1, 30); cyc();
    chk("lat3_de", int'(bus.de_out), 1);
    chk("lat3_hs", int'(bus.hsync_out), 1);
    chk("lat3_vs", int'(bus.vsync_out), 1);
    chk("lat3_y", int'(bus.y_data[9:0]), 40);
    drive(1'b1, 40); cyc();
    chk("lat4_hs", int'(bus.hsync_out), 0);
    idle(4);
    px = '{10, 20, 30, 40}; ec = '{60, 60, 140, 140}; eps = '{1, 0, 1, 0};
    check_line("t1", px, ec, eps);

    // 2: odd line then a one-gap restart
    px = '{10, 20, 30}; send_line(px, -1);
    idle(1);
    px = '{5, 7}; send_line(px, -1);
    idle(4);
    px = '{10, 20, 30, 5, 7}; ec = '{60, 60, 120, 24, 24}; eps = '{1, 0, 1, 1, 0};
    check_line("t2", px, ec, eps);

    // 3: 3-tap line
    bus.mode = 1'b1;
    idle(3);
    px = '{10, 20, 30}; send_line(px, -1);
    idle(4);
    ec = '{50, 80, 110}; eps = '{1, 0, 1};
    check_line("t3", px, ec, eps);

    // 4: full scale, no wrap, every channel
    px = '{255, 255, 255, 255}; send_line(px, -1);
    chk("t4_word", (bus.c_data == {3{10'd1020}}) ? 1 : 0, 1);
    idle(4);
    ec = '{1020, 1020, 1020, 1020}; eps = '{1, 0, 1, 0};
    check_line("t4", px, ec, eps);

    // one-pixel lines, both modes
    px = '{9}; send_line(px, -1);
    idle(4);
    ec = '{36}; eps = '{1};
    check_line("t1px_m1", px, ec, eps);
    bus.mode = 1'b0;
    idle(3);
    px = '{9}; send_line(px, -1);
    idle(4);
    check_line("t1px_m0", px, ec, eps);

    // 5: mode flips mid-line; takes effect only on the following line
    px = '{10, 20, 30, 40}; send_line(px, 2);
    idle(4);
    ec = '{60, 60, 140, 140}; eps = '{1, 0, 1, 0};
    check_line("t5a", px, ec, eps);
    px = '{10, 20, 30}; send_line(px, -1);
    idle(4);
    ec = '{50, 80, 110}; eps = '{1, 0, 1};
    check_line("t5b", px, ec, eps);

    // asynchronous reset mid-line
    px = '{10, 20, 30, 40, 50}; send_line(px, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_y", int'(bus.y_data), 0);
    chk("mrst_c", int'(bus.c_data), 0);
    chk("mrst_ps", int'(bus.pair_start), 0);
    chk("mrst_de", int'(bus.de_out), 0);
    drive(1'b0, 0);
    bus.mode = 1'b0;
    #13 rst_n = 1'b1;
    yq.delete(); cq.delete(); pq.delete();
    idle(3);
    px = '{5, 7}; send_line(px, -1);
    idle(4);
    ec = '{24, 24}; eps = '{1, 0};
    check_line("t5r", px, ec, eps);

`ifdef LINE_STATS_EN
    stb_cnt = 0;
    stb_after_last = 0;
    px = '{1, 2, 3, 4, 5}; send_line(px, -1);
    idle(6);
    chk("t6_len", int'(line_len), 5);
    chk("t6_odd", int'(line_odd), 1);
    chk("t6_stb_cnt", stb_cnt, 1);
    chk("t6_stb_pos", stb_after_last, 1);
    yq.delete(); cq.delete(); pq.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
